// File: rtl/tank_pkg.sv
// Shared constants, types and overlap helper for the tank frame-rate blocks.
package tank_pkg;

  localparam logic [1:0] MODE_PLAY = 2'b10;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    HIT_FLASH = 2'd1,
    INVULN    = 2'd2,
    DEAD      = 2'd3
  } hit_state_t;

  localparam logic [9:0] TANK_SIZE_DEF   = 10'd32;
  localparam logic [9:0] BULLET_SIZE_DEF = 10'd3;

  // One-axis overlap of a point against [lo, lo+size-1] grown by rad on each side.
  // Carried in 11 bits and written without subtraction on the point side so a box
  // near 0 or near 1023 never wraps.
  function automatic logic span_hit(input logic [9:0] pos, input logic [9:0] lo,
                                    input logic [9:0] size, input logic [9:0] rad);
    logic [10:0] w_pos_hi;
    logic [10:0] w_box_hi;
    w_pos_hi = {1'b0, pos} + {1'b0, rad};
    w_box_hi = {1'b0, lo} + {1'b0, size} - 11'd1 + {1'b0, rad};
    return (w_pos_hi >= {1'b0, lo}) && ({1'b0, pos} <= w_box_hi);
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Synchronises the vsync-rate frame clock into Clk and emits a one-Clk pulse per
// rising edge, two Clk after the input rises.
module frame_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic i_frame_clk,
  output logic o_fe
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_frame_clk;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_fe = r_sync & ~r_prev;

endmodule

// File: rtl/tank_hit_tracker.sv
// Tank hit tracker: bursts the opponent bullet on overlap and runs this tank's
// health through ALIVE / HIT_FLASH / INVULN / DEAD. Define TANK_REGEN_EN to let
// health regenerate by one every REGEN_FRAMES frames while ALIVE and damaged.
module tank_hit_tracker
  import tank_pkg::*;
#(
  parameter logic [9:0] TANK_SIZE     = TANK_SIZE_DEF,
  parameter logic [9:0] BULLET_SIZE   = BULLET_SIZE_DEF,
  parameter logic [2:0] MAX_HEALTH    = 3'd3,
  parameter logic [7:0] FLASH_FRAMES  = 8'd30,
  parameter logic [7:0] INVULN_FRAMES = 8'd60
`ifdef TANK_REGEN_EN
  ,
  parameter logic [9:0] REGEN_FRAMES  = 10'd600
`endif
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_frame_clk,
  input  logic [1:0] i_mode,
  input  logic [9:0] i_bullet_x,
  input  logic [9:0] i_bullet_y,
  input  logic       i_bullet_active,
  input  logic [9:0] i_tank_x,
  input  logic [9:0] i_tank_y,
  output logic       o_stop_bullet,
  output logic       o_hit_pulse,
  output logic [2:0] o_health,
  output logic       o_dead,
  output logic       o_flash
);

  logic       w_fe;
  logic       w_play;
  logic       w_overlap;
  logic       w_new_hit;
  logic       r_stop;
  logic       r_stop_prev;
  hit_state_t r_state,  w_state_d;
  logic [2:0] r_health, w_health_d;
  logic [7:0] r_cnt,    w_cnt_d;
  logic       r_hit,    w_hit_d;
`ifdef TANK_REGEN_EN
  logic [9:0] r_regen,  w_regen_d;
`endif

  frame_edge_detect u_fe (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_frame_clk (i_frame_clk),
    .o_fe        (w_fe)
  );

  assign w_play    = (i_mode == MODE_PLAY);
  assign w_overlap = span_hit(i_bullet_x, i_tank_x, TANK_SIZE, BULLET_SIZE) &
                     span_hit(i_bullet_y, i_tank_y, TANK_SIZE, BULLET_SIZE);
  // A lingering overlap is a single impact; only a fresh stop_bullet counts.
  assign w_new_hit = r_stop & ~r_stop_prev;

  // Registered burst request, raised in every state while in play.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stop      <= 1'b0;
      r_stop_prev <= 1'b0;
    end else begin
      r_stop      <= w_overlap & i_bullet_active & w_play;
      r_stop_prev <= r_stop;
    end
  end

  // Next-state logic for the hit FSM, frame counter and health.
  always_comb begin
    w_state_d  = r_state;
    w_health_d = r_health;
    w_cnt_d    = r_cnt;
    w_hit_d    = 1'b0;
`ifdef TANK_REGEN_EN
    w_regen_d  = r_regen;
`endif
    if (!w_play) begin
      w_state_d  = ALIVE;
      w_health_d = MAX_HEALTH;
      w_cnt_d    = 8'd0;
`ifdef TANK_REGEN_EN
      w_regen_d  = 10'd0;
`endif
    end else begin
      unique case (r_state)
        ALIVE: begin
          if (w_new_hit) begin
            w_hit_d    = 1'b1;
            w_cnt_d    = 8'd0;
            w_health_d = (r_health == 3'd0) ? 3'd0 : r_health - 3'd1;
            w_state_d  = (r_health <= 3'd1) ? DEAD : HIT_FLASH;
`ifdef TANK_REGEN_EN
            w_regen_d  = 10'd0;
          end else if (r_health >= MAX_HEALTH) begin
            w_regen_d  = 10'd0;
          end else if (w_fe) begin
            if (r_regen == REGEN_FRAMES - 10'd1) begin
              w_regen_d  = 10'd0;
              w_health_d = r_health + 3'd1;
            end else begin
              w_regen_d  = r_regen + 10'd1;
            end
`endif
          end
        end
        HIT_FLASH: begin
          if (w_fe) begin
            if (r_cnt == FLASH_FRAMES - 8'd1) begin
              w_state_d = INVULN;
              w_cnt_d   = 8'd0;
            end else begin
              w_cnt_d   = r_cnt + 8'd1;
            end
          end
        end
        INVULN: begin
          if (w_fe) begin
            if (r_cnt == INVULN_FRAMES - 8'd1) begin
              w_state_d = ALIVE;
              w_cnt_d   = 8'd0;
            end else begin
              w_cnt_d   = r_cnt + 8'd1;
            end
          end
        end
        DEAD: begin
        end
        default: w_state_d = ALIVE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= ALIVE;
      r_health <= MAX_HEALTH;
      r_cnt    <= 8'd0;
      r_hit    <= 1'b0;
`ifdef TANK_REGEN_EN
      r_regen  <= 10'd0;
`endif
    end else begin
      r_state  <= w_state_d;
      r_health <= w_health_d;
      r_cnt    <= w_cnt_d;
      r_hit    <= w_hit_d;
`ifdef TANK_REGEN_EN
      r_regen  <= w_regen_d;
`endif
    end
  end

  // Blink: slow toggle while flashing, slower while invulnerable.
  always_comb begin
    o_flash = 1'b0;
    if (r_state == HIT_FLASH)   o_flash = r_cnt[2];
    else if (r_state == INVULN) o_flash = r_cnt[3];
  end

  assign o_stop_bullet = r_stop;
  assign o_hit_pulse   = r_hit;
  assign o_health      = r_health;
  assign o_dead        = (r_state == DEAD);

endmodule

// File: tb/tb_tank_hit_tracker.sv
// Directed bench for tank_hit_tracker: overlap edges, hit/flash/invuln timing,
// death, mode exit, mid-flash reset and optional regeneration.
module tb_tank_hit_tracker;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [1:0] mode;
  logic [9:0] bullet_x, bullet_y, tank_x, tank_y;
  logic       bullet_active;
  logic       stop_bullet, hit_pulse, dead, flash;
  logic [2:0] health;

  int tests   = 0;
  int fails   = 0;
  int hit_cnt = 0;

  tank_hit_tracker dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .i_frame_clk     (frame_clk),
    .i_mode          (mode),
    .i_bullet_x      (bullet_x),
    .i_bullet_y      (bullet_y),
    .i_bullet_active (bullet_active),
    .i_tank_x        (tank_x),
    .i_tank_y        (tank_y),
    .o_stop_bullet   (stop_bullet),
    .o_hit_pulse     (hit_pulse),
    .o_health        (health),
    .o_dead          (dead),
    .o_flash         (flash)
  );

  always #5 Clk = ~Clk;

  // Counts hit pulses seen on the clock edge following each pulse cycle.
  always @(posedge Clk) if (hit_pulse === 1'b1) hit_cnt <= hit_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      cyc(3);
      frame_clk = 1'b0;
      cyc(3);
    end
  endtask

  task automatic set_bullet(input logic [9:0] x, input logic [9:0] y, input logic a);
    bullet_x      = x;
    bullet_y      = y;
    bullet_active = a;
  endtask

  task automatic hit_and_clear();
    set_bullet(10'd98, 10'd110, 1'b1);
    cyc(4);
    set_bullet(10'd0, 10'd0, 1'b0);
    cyc(2);
  endtask

  initial begin
    Reset     = 1'b1;
    frame_clk = 1'b0;
    mode      = 2'b10;
    tank_x    = 10'd100;
    tank_y    = 10'd100;
    set_bullet(10'd0, 10'd0, 1'b0);
    cyc(3);
    chk("rst_stop",   32'(stop_bullet), 0);
    chk("rst_hit",    32'(hit_pulse),   0);
    chk("rst_health", 32'(health),      3);
    chk("rst_dead",   32'(dead),        0);
    chk("rst_flash",  32'(flash),       0);
    Reset = 1'b0;
    cyc(2);

    // T1: first hit
    set_bullet(10'd98, 10'd110, 1'b1);
    cyc(1);
    chk("t1_stop_lat",   32'(stop_bullet), 1);
    chk("t1_health_pre", 32'(health),      3);
    cyc(1);
    chk("t1_pulse",      32'(hit_pulse),   1);
    chk("t1_health",     32'(health),      2);
    cyc(1);
    chk("t1_pulse_end",  32'(hit_pulse),   0);
    cyc(2);
    chk("t1_hit_cnt",    32'(hit_cnt),     1);

    // T2: persistent overlap through flash and invuln
    frames(3);
    chk("t2_flash_f3",   32'(flash), 0);
    frames(1);
    chk("t2_flash_f4",   32'(flash), 1);
    frames(34);
    chk("t2_flash_f38",  32'(flash), 1);
    chk("t2_health_f38", 32'(health), 2);
    frames(51);
    chk("t2_flash_f89",  32'(flash), 1);
    frames(1);
    chk("t2_flash_f90",  32'(flash), 0);
    chk("t2_stop_f90",   32'(stop_bullet), 1);
    frames(110);
    chk("t2_health_f200", 32'(health), 2);
    chk("t2_stop_f200",   32'(stop_bullet), 1);
    chk("t2_hits_f200",   32'(hit_cnt), 1);
    chk("t2_dead_f200",   32'(dead), 0);

    // T3: X boundary one pixel outside, then exactly on the edge
    set_bullet(10'd96, 10'd110, 1'b1);
    cyc(2);
    chk("t3_out_stop",   32'(stop_bullet), 0);
    cyc(2);
    chk("t3_out_health", 32'(health), 2);
    chk("t3_out_hits",   32'(hit_cnt), 1);
    set_bullet(10'd97, 10'd110, 1'b1);
    cyc(1);
    chk("t3_in_stop",    32'(stop_bullet), 1);
    cyc(3);
    chk("t3_in_health",  32'(health), 1);
    chk("t3_in_hits",    32'(hit_cnt), 2);
    // Y boundary, checked while in HIT_FLASH
    set_bullet(10'd110, 10'd135, 1'b1);
    cyc(2);
    chk("t3_y_out_stop", 32'(stop_bullet), 0);
    set_bullet(10'd110, 10'd134, 1'b1);
    cyc(2);
    chk("t3_y_in_stop",  32'(stop_bullet), 1);
    chk("t3_flash_hits", 32'(hit_cnt), 2);

    // T5: reset mid-flash with the bullet still overlapping
    frames(5);
    chk("t5_flash_pre",  32'(flash), 1);
    Reset = 1'b1;
    cyc(1);
    chk("t5_stop",   32'(stop_bullet), 0);
    chk("t5_hit",    32'(hit_pulse),   0);
    chk("t5_health", 32'(health),      3);
    chk("t5_dead",   32'(dead),        0);
    chk("t5_flash",  32'(flash),       0);
    set_bullet(10'd0, 10'd0, 1'b0);
    cyc(1);
    Reset = 1'b0;
    cyc(2);

    // T4: three separated hits, a hit ignored while invulnerable, then mode exit
    hit_and_clear();
    chk("t4_h1_health", 32'(health), 2);
    chk("t4_h1_hits",   32'(hit_cnt), 3);
    frames(40);
    set_bullet(10'd98, 10'd110, 1'b1);
    cyc(3);
    chk("t4_inv_stop",   32'(stop_bullet), 1);
    chk("t4_inv_health", 32'(health), 2);
    chk("t4_inv_hits",   32'(hit_cnt), 3);
    set_bullet(10'd0, 10'd0, 1'b0);
    cyc(2);
    frames(50);
    chk("t4_back_flash", 32'(flash), 0);
    hit_and_clear();
    chk("t4_h2_health", 32'(health), 1);
    frames(90);
    hit_and_clear();
    chk("t4_h3_health", 32'(health), 0);
    chk("t4_h3_dead",   32'(dead), 1);
    chk("t4_h3_flash",  32'(flash), 0);
    chk("t4_h3_hits",   32'(hit_cnt), 5);
    frames(5);
    set_bullet(10'd98, 10'd110, 1'b1);
    cyc(3);
    chk("t4_dead_stop",   32'(stop_bullet), 1);
    chk("t4_dead_health", 32'(health), 0);
    chk("t4_dead_hold",   32'(dead), 1);
    chk("t4_dead_hits",   32'(hit_cnt), 5);
    mode = 2'b00;
    cyc(1);
    chk("t4_exit_health", 32'(health), 3);
    chk("t4_exit_dead",   32'(dead), 0);
    chk("t4_exit_stop",   32'(stop_bullet), 0);
    chk("t4_exit_flash",  32'(flash), 0);
    set_bullet(10'd0, 10'd0, 1'b0);
    mode = 2'b10;
    cyc(2);

    // T6: regeneration after 600 quiet frames in ALIVE
    hit_and_clear();
    chk("t6_health_hit", 32'(health), 2);
    frames(90);
    frames(599);
    chk("t6_health_599", 32'(health), 2);
    frames(1);
`ifdef TANK_REGEN_EN
    chk("t6_health_600", 32'(health), 3);
`else
    chk("t6_health_600", 32'(health), 2);
`endif
    chk("t6_hits", 32'(hit_cnt), 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
